// File: rtl/axi_lite_mem_arbiter_pkg.sv
// Shared AXI-lite widths and arbiter encodings for the IFU/LSU memory arbiter.
// The package is called axi_pkg because it is meant to be shared by other AXI-lite blocks.
package axi_pkg;
    localparam int AXI_ADDR  = 32;
    localparam int AXI_DATA  = 32;
    localparam int AXI_WSTRB = 4;
    localparam int AXI_RESP  = 2;

    typedef enum logic [2:0] {
        IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R, LSU_W, LSU_B
    } arb_state_e;

    typedef enum logic {
        GRANT_IFU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_e;
endpackage

// File: rtl/axi_lite_mem_arbiter_rr.sv
// Two-requester round-robin picker: bit 0 = IFU, bit 1 = LSU, one-hot grant.
// On a tie, the requester that was not served last wins.
module rr_arbiter2
    import axi_pkg::*;
(
    input  logic [1:0] req_i,
    input  grant_e     last_grant_i,
    output logic [1:0] gnt_o
);
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11)
            gnt_o = (last_grant_i == GRANT_LSU) ? 2'b01 : 2'b10;
    end
endmodule

// File: rtl/axi_lite_mem_arbiter.sv
// Shares one AXI-lite memory slave between the IFU (read-only) and the LSU (read/write).
// One transaction is in flight at a time; all channel routing is combinational from the state.
module axi_lite_mem_arbiter
    import axi_pkg::*;
#(
    parameter logic RR_INIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AXI_ADDR-1:0]  ifu_araddr,
    input  logic                 ifu_arvalid,
    output logic                 ifu_arready,
    output logic [AXI_DATA-1:0]  ifu_rdata,
    output logic [AXI_RESP-1:0]  ifu_rresp,
    output logic                 ifu_rvalid,
    input  logic                 ifu_rready,
    input  logic [AXI_ADDR-1:0]  lsu_araddr,
    input  logic                 lsu_arvalid,
    output logic                 lsu_arready,
    output logic [AXI_DATA-1:0]  lsu_rdata,
    output logic [AXI_RESP-1:0]  lsu_rresp,
    output logic                 lsu_rvalid,
    input  logic                 lsu_rready,
    input  logic [AXI_ADDR-1:0]  lsu_awaddr,
    input  logic                 lsu_awvalid,
    output logic                 lsu_awready,
    input  logic [AXI_DATA-1:0]  lsu_wdata,
    input  logic [AXI_WSTRB-1:0] lsu_wstrb,
    input  logic                 lsu_wvalid,
    output logic                 lsu_wready,
    output logic [AXI_RESP-1:0]  lsu_bresp,
    output logic                 lsu_bvalid,
    input  logic                 lsu_bready,
    output logic [AXI_ADDR-1:0]  mem_araddr,
    output logic                 mem_arvalid,
    input  logic                 mem_arready,
    input  logic [AXI_DATA-1:0]  mem_rdata,
    input  logic [AXI_RESP-1:0]  mem_rresp,
    input  logic                 mem_rvalid,
    output logic                 mem_rready,
    output logic [AXI_ADDR-1:0]  mem_awaddr,
    output logic                 mem_awvalid,
    input  logic                 mem_awready,
    output logic [AXI_DATA-1:0]  mem_wdata,
    output logic [AXI_WSTRB-1:0] mem_wstrb,
    output logic                 mem_wvalid,
    input  logic                 mem_wready,
    input  logic [AXI_RESP-1:0]  mem_bresp,
    input  logic                 mem_bvalid,
    output logic                 mem_bready
);
    arb_state_e state_q, state_d;
    grant_e     last_grant_q, last_grant_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;
    logic [1:0] req, gnt;

    assign req = {lsu_awvalid | lsu_arvalid, ifu_arvalid};

    rr_arbiter2 u_rr (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt)
    );

    always_comb begin
        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = '0;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = '0;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = '0;
        lsu_bvalid  = 1'b0;
        mem_araddr  = '0;
        mem_arvalid = 1'b0;
        mem_rready  = 1'b0;
        mem_awaddr  = '0;
        mem_awvalid = 1'b0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        mem_wvalid  = 1'b0;
        mem_bready  = 1'b0;
        case (state_q)
            IFU_AR: begin
                mem_araddr  = ifu_araddr;
                mem_arvalid = ifu_arvalid;
                ifu_arready = mem_arready;
            end
            IFU_R: begin
                ifu_rdata  = mem_rdata;
                ifu_rresp  = mem_rresp;
                ifu_rvalid = mem_rvalid;
                mem_rready = ifu_rready;
            end
            LSU_AR: begin
                mem_araddr  = lsu_araddr;
                mem_arvalid = lsu_arvalid;
                lsu_arready = mem_arready;
            end
            LSU_R: begin
                lsu_rdata  = mem_rdata;
                lsu_rresp  = mem_rresp;
                lsu_rvalid = mem_rvalid;
                mem_rready = lsu_rready;
            end
            // AW and W complete independently; a finished channel is masked off.
            LSU_W: begin
                mem_awaddr  = lsu_awaddr;
                mem_awvalid = lsu_awvalid & ~aw_done_q;
                lsu_awready = mem_awready & ~aw_done_q;
                mem_wdata   = lsu_wdata;
                mem_wstrb   = lsu_wstrb;
                mem_wvalid  = lsu_wvalid & ~w_done_q;
                lsu_wready  = mem_wready & ~w_done_q;
            end
            LSU_B: begin
                lsu_bresp  = mem_bresp;
                lsu_bvalid = mem_bvalid;
                mem_bready = lsu_bready;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        case (state_q)
            // Granting always costs this one IDLE cycle; no ready is raised here.
            IDLE: begin
                if (gnt[1]) begin
                    last_grant_d = GRANT_LSU;
                    state_d      = lsu_awvalid ? LSU_W : LSU_AR;
                end else if (gnt[0]) begin
                    last_grant_d = GRANT_IFU;
                    state_d      = IFU_AR;
                end
            end
            IFU_AR: if (mem_arvalid & mem_arready) state_d = IFU_R;
            IFU_R:  if (mem_rvalid & mem_rready)   state_d = IDLE;
            LSU_AR: if (mem_arvalid & mem_arready) state_d = LSU_R;
            LSU_R:  if (mem_rvalid & mem_rready)   state_d = IDLE;
            LSU_W: begin
                aw_done_d = aw_done_q | (mem_awvalid & mem_awready);
                w_done_d  = w_done_q | (mem_wvalid & mem_wready);
                if (aw_done_d & w_done_d) state_d = LSU_B;
            end
            LSU_B: begin
                if (mem_bvalid & mem_bready) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= grant_e'(RR_INIT);
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
        end
    end
endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Bench for axi_lite_mem_arbiter: IFU/LSU master drivers, a behavioural SRAM slave,
// a word-level reference memory feeding response queues, and a negedge monitor.
module tb_axi_lite_mem_arbiter;
    import axi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] ifu_araddr = '0, lsu_araddr = '0, lsu_awaddr = '0, lsu_wdata = '0;
    logic        ifu_arvalid = 0, ifu_rready = 0, lsu_arvalid = 0, lsu_rready = 0;
    logic        lsu_awvalid = 0, lsu_wvalid = 0, lsu_bready = 0;
    logic [3:0]  lsu_wstrb = '0;
    logic        ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid;
    logic [31:0] ifu_rdata, lsu_rdata;
    logic [1:0]  ifu_rresp, lsu_rresp, lsu_bresp;
    logic [31:0] mem_araddr, mem_awaddr, mem_wdata;
    logic        mem_arvalid, mem_rready, mem_awvalid, mem_wvalid, mem_bready;
    logic [3:0]  mem_wstrb;
    logic        mem_arready = 0, mem_rvalid = 0, mem_awready = 0, mem_wready = 0, mem_bvalid = 0;
    logic [31:0] mem_rdata = '0;
    logic [1:0]  mem_rresp = '0, mem_bresp = '0;

    axi_lite_mem_arbiter #(.RR_INIT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
        .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
        .mem_awaddr(mem_awaddr), .mem_awvalid(mem_awvalid), .mem_awready(mem_awready),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_bresp(mem_bresp), .mem_bvalid(mem_bvalid), .mem_bready(mem_bready)
    );

    logic [181:0] all_out;
    assign all_out = {ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid,
                      lsu_arready, lsu_rdata, lsu_rresp, lsu_rvalid,
                      lsu_awready, lsu_wready, lsu_bresp, lsu_bvalid,
                      mem_araddr, mem_arvalid, mem_rready, mem_awaddr, mem_awvalid,
                      mem_wdata, mem_wstrb, mem_wvalid, mem_bready};

    int checks = 0, errors = 0;
    typedef struct { logic [31:0] data; logic [1:0] resp; } rsp_t;
    rsp_t        ifu_q[$], lsu_q[$];
    logic [1:0]  lsu_b_q[$];
    int          served[$];      // 0 = IFU read, 1 = LSU read, 2 = LSU write
    int          bv_cyc = 0;
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];
    bit          cfg_rand = 0, rdy_rand = 0;
    int          cfg_ar = 0, cfg_r = 0, cfg_aw = 0, cfg_w = 0, cfg_b = 0;
    int          aw_n = 0, w_n = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0413 : {a[15:0], ~a[15:0]};
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction
    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : init_word(a);
    endfunction
    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction
    function automatic int wt(input int f);
        return cfg_rand ? int'($urandom_range(0, 3)) : f;
    endfunction
    function automatic logic rdy();
        return rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    // Handshakes as seen just before each rising edge; drivers act on these after the edge.
    logic c_ifu_ar, c_ifu_r, c_lsu_ar, c_lsu_r, c_lsu_aw, c_lsu_w, c_lsu_b;
    logic c_m_ar, c_m_arv, c_m_r, c_m_aw, c_m_awv, c_m_w, c_m_wv, c_m_b;
    logic [31:0] c_m_araddr, c_m_awaddr, c_m_wdata;
    logic [3:0]  c_m_wstrb;
    always @(negedge clk) begin
        c_ifu_ar <= ifu_arvalid & ifu_arready;  c_ifu_r <= ifu_rvalid & ifu_rready;
        c_lsu_ar <= lsu_arvalid & lsu_arready;  c_lsu_r <= lsu_rvalid & lsu_rready;
        c_lsu_aw <= lsu_awvalid & lsu_awready;  c_lsu_w <= lsu_wvalid & lsu_wready;
        c_lsu_b  <= lsu_bvalid & lsu_bready;
        c_m_ar <= mem_arvalid & mem_arready;  c_m_arv <= mem_arvalid;  c_m_araddr <= mem_araddr;
        c_m_r  <= mem_rvalid & mem_rready;
        c_m_aw <= mem_awvalid & mem_awready;  c_m_awv <= mem_awvalid;  c_m_awaddr <= mem_awaddr;
        c_m_w  <= mem_wvalid & mem_wready;    c_m_wv <= mem_wvalid;
        c_m_wdata <= mem_wdata;  c_m_wstrb <= mem_wstrb;
        c_m_b  <= mem_bvalid & mem_bready;
    end

    // Monitor: scoreboard pops plus cross-master isolation checks.
    always @(negedge clk) begin
        rsp_t e;
        logic [1:0] br;
        if (!rst) begin
            if (ifu_rvalid && ifu_rready) begin
                served.push_back(0);
                if (ifu_q.size() == 0) chk("ifu_r_unexpected", 64'(1), 64'(0));
                else begin
                    e = ifu_q.pop_front();
                    chk("ifu_rdata", 64'(ifu_rdata), 64'(e.data));
                    chk("ifu_rresp", 64'(ifu_rresp), 64'(e.resp));
                end
            end
            if (lsu_rvalid && lsu_rready) begin
                served.push_back(1);
                if (lsu_q.size() == 0) chk("lsu_r_unexpected", 64'(1), 64'(0));
                else begin
                    e = lsu_q.pop_front();
                    chk("lsu_rdata", 64'(lsu_rdata), 64'(e.data));
                    chk("lsu_rresp", 64'(lsu_rresp), 64'(e.resp));
                end
            end
            if (lsu_bvalid) bv_cyc++;
            if (lsu_bvalid && lsu_bready) begin
                served.push_back(2);
                if (lsu_b_q.size() == 0) chk("lsu_b_unexpected", 64'(1), 64'(0));
                else begin
                    br = lsu_b_q.pop_front();
                    chk("lsu_bresp", 64'(lsu_bresp), 64'(br));
                end
            end
            chk("mem_ar_vs_w", 64'(mem_arvalid & (mem_awvalid | mem_wvalid)), 64'(0));
            chk("ifu_isolated",
                64'((lsu_arready | lsu_rvalid | lsu_awready | lsu_wready | lsu_bvalid | mem_awvalid | mem_wvalid)
                    & (ifu_arready | ifu_rvalid | (|ifu_rdata) | (|ifu_rresp))), 64'(0));
            chk("lsu_isolated",
                64'((ifu_arready | ifu_rvalid) & (lsu_arready | lsu_rvalid | (|lsu_rdata) | (|lsu_rresp)
                    | lsu_awready | lsu_wready | lsu_bvalid | (|lsu_bresp))), 64'(0));
        end
    end

    // Behavioural SRAM slave with programmable wait states.
    initial begin
        bit r_pend = 0, aw_got = 0, w_got = 0, b_pend = 0;
        int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
        logic [31:0] rd_addr = '0, wa = '0, wd = '0;
        logic [3:0]  ws = '0;
        logic [1:0]  bresp_r = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0; aw_n = 0; w_n = 0;
                ar_cnt = wt(cfg_ar); aw_cnt = wt(cfg_aw); w_cnt = wt(cfg_w);
                mem_arready = 0; mem_rvalid = 0; mem_awready = 0; mem_wready = 0; mem_bvalid = 0;
                continue;
            end
            if (c_m_r) r_pend = 0; else if (r_pend && r_cnt > 0) r_cnt--;
            if (c_m_ar) begin r_pend = 1; rd_addr = c_m_araddr; r_cnt = wt(cfg_r); ar_cnt = wt(cfg_ar); end
            else if (c_m_arv && ar_cnt > 0) ar_cnt--;
            if (c_m_b) b_pend = 0; else if (b_pend && b_cnt > 0) b_cnt--;
            if (c_m_aw) begin aw_got = 1; wa = c_m_awaddr; aw_n++; aw_cnt = wt(cfg_aw); end
            else if (c_m_awv && aw_cnt > 0) aw_cnt--;
            if (c_m_w) begin w_got = 1; wd = c_m_wdata; ws = c_m_wstrb; w_n++; w_cnt = wt(cfg_w); end
            else if (c_m_wv && w_cnt > 0) w_cnt--;
            if (aw_got && w_got) begin
                slv_mem[wa] = merge(slv_rd(wa), wd, ws);
                aw_got = 0; w_got = 0; b_pend = 1; b_cnt = wt(cfg_b); bresp_r = wa[5:4];
            end
            mem_arready = !r_pend && ar_cnt == 0;
            mem_rvalid  = r_pend && r_cnt == 0;
            mem_rdata   = mem_rvalid ? slv_rd(rd_addr) : $urandom;
            mem_rresp   = mem_rvalid ? rd_addr[5:4] : 2'($urandom);
            mem_awready = !b_pend && !aw_got && aw_cnt == 0;
            mem_wready  = !b_pend && !w_got && w_cnt == 0;
            mem_bvalid  = b_pend && b_cnt == 0;
            mem_bresp   = mem_bvalid ? bresp_r : 2'($urandom);
        end
    end

    task automatic ifu_read(input logic [31:0] a, output int cyc);
        rsp_t e;
        e.data = ref_rd(a); e.resp = a[5:4];
        ifu_q.push_back(e);
        ifu_araddr = a; ifu_arvalid = 1; ifu_rready = rdy(); cyc = 0;
        while (1) begin
            @(posedge clk); #1; cyc++;
            if (c_ifu_ar) begin ifu_arvalid = 0; ifu_araddr = $urandom; end
            if (c_ifu_r) break;
            if (cyc > 300) begin chk("ifu_timeout", 64'(1), 64'(0)); ifu_arvalid = 0; break; end
            ifu_rready = rdy();
        end
        ifu_rready = 0;
    endtask

    task automatic lsu_read(input logic [31:0] a, output int cyc);
        rsp_t e;
        e.data = ref_rd(a); e.resp = a[5:4];
        lsu_q.push_back(e);
        lsu_araddr = a; lsu_arvalid = 1; lsu_rready = rdy(); cyc = 0;
        while (1) begin
            @(posedge clk); #1; cyc++;
            if (c_lsu_ar) begin lsu_arvalid = 0; lsu_araddr = $urandom; end
            if (c_lsu_r) break;
            if (cyc > 300) begin chk("lsu_r_timeout", 64'(1), 64'(0)); lsu_arvalid = 0; break; end
            lsu_rready = rdy();
        end
        lsu_rready = 0;
    endtask

    task automatic lsu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output int cyc);
        ref_mem[a] = merge(ref_rd(a), d, s);
        lsu_b_q.push_back(a[5:4]);
        lsu_awaddr = a; lsu_wdata = d; lsu_wstrb = s;
        lsu_awvalid = 1; lsu_wvalid = 1; lsu_bready = rdy(); cyc = 0;
        while (1) begin
            @(posedge clk); #1; cyc++;
            if (c_lsu_aw) lsu_awvalid = 0;
            if (c_lsu_w) lsu_wvalid = 0;
            if (c_lsu_b) break;
            if (cyc > 300) begin
                chk("lsu_w_timeout", 64'(1), 64'(0)); lsu_awvalid = 0; lsu_wvalid = 0; break;
            end
            lsu_bready = rdy();
        end
        lsu_bready = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        ifu_q.delete(); lsu_q.delete(); lsu_b_q.delete(); served.delete(); bv_cyc = 0;
        @(negedge clk) rst = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int c1, c2, lim;
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", 64'(|all_out), 64'(0));
        @(negedge clk) rst = 0;

        // IFU alone, 3 read wait states, then zero-wait minimum latencies.
        cfg_r = 3;
        ifu_read(32'h8000_0000, c1);
        chk("ifu_read_wait3_cycles", 64'(c1), 64'(6));
        cfg_r = 0;
        ifu_read(32'h8000_0004, c1);
        chk("read_min_latency", 64'(c1), 64'(3));
        lsu_write(32'h8000_1100, 32'h1234_5678, 4'hF, c1);
        chk("write_min_latency", 64'(c1), 64'(3));

        // Reset asserted while IFU_R is presenting mem_rvalid.
        ifu_araddr = 32'h8000_0008; ifu_arvalid = 1; ifu_rready = 0;
        lim = 0;
        while (!ifu_rvalid && lim < 20) begin @(negedge clk); lim++; end
        chk("ifu_rvalid_before_rst", 64'(ifu_rvalid), 64'(1));
        #2 rst = 1;
        #1 chk("async_reset_outputs", 64'(|all_out), 64'(0));
        ifu_arvalid = 0;
        do_reset();

        // Simultaneous IFU/LSU reads right after reset: LSU goes first.
        fork
            ifu_read(32'h8000_0010, c1);
            lsu_read(32'h8000_1000, c2);
        join
        chk("tie_first_is_lsu", 64'(served.size() > 0 ? served[0] : -1), 64'(1));
        chk("tie_second_is_ifu", 64'(served.size() > 1 ? served[1] : -1), 64'(0));
        chk("tie_lsu_cycles", 64'(c2), 64'(3));
        chk("tie_ifu_cycles", 64'(c1), 64'(6));

        // Write with W accepted before AW; each accepted once, one-cycle B.
        cfg_aw = 2;
        do_reset();
        lsu_write(32'h8000_2000, 32'hDEAD_BEEF, 4'hF, c1);
        chk("aw_accept_count", 64'(aw_n), 64'(1));
        chk("w_accept_count", 64'(w_n), 64'(1));
        chk("bvalid_cycles", 64'(bv_cyc), 64'(1));
        chk("slave_word", 64'(slv_rd(32'h8000_2000)), 64'h0000_0000_DEAD_BEEF);
        lsu_read(32'h8000_2000, c1);
        cfg_aw = 0;

        // LSU write and read requested together: write first.
        do_reset();
        fork
            lsu_write(32'h8000_1200, 32'hCAFE_F00D, 4'h5, c1);
            lsu_read(32'h8000_1204, c2);
        join
        chk("lsu_write_before_read", 64'(served.size() > 0 ? served[0] : -1), 64'(2));
        chk("lsu_read_after_write", 64'(served.size() > 1 ? served[1] : -1), 64'(1));

        // Both masters always requesting: strict alternation.
        do_reset();
        fork
            begin int d; for (int k = 0; k < 15; k++) ifu_read(32'h8000_0000 + {$urandom_range(0, 63), 2'b00}, d); end
            begin int d; for (int k = 0; k < 15; k++) lsu_read(32'h8000_1000 + {$urandom_range(0, 63), 2'b00}, d); end
        join
        chk("alt_count", 64'(served.size()), 64'(30));
        for (int i = 0; i < served.size() && i < 30; i++)
            chk("alternation", 64'(served[i]), 64'((i % 2 == 0) ? 1 : 0));

        // Randomized traffic with random wait states and backpressure.
        cfg_rand = 1; rdy_rand = 1;
        do_reset();
        fork
            begin
                int d;
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1 ifu_read(32'h8000_0000 + {$urandom_range(0, 63), 2'b00}, d);
                end
            end
            begin
                int d;
                logic [31:0] a;
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1 a = 32'h8000_1000 + {$urandom_range(0, 31), 2'b00};
                    if ($urandom_range(0, 1) == 1) lsu_write(a, $urandom, 4'($urandom_range(1, 15)), d);
                    else lsu_read(a, d);
                end
            end
        join
        repeat (10) @(posedge clk);
        #1;
        chk("ifu_q_drained", 64'(ifu_q.size()), 64'(0));
        chk("lsu_q_drained", 64'(lsu_q.size()), 64'(0));
        chk("lsu_b_q_drained", 64'(lsu_b_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_lite_mem_arbiter.md
Name: axi_lite_mem_arbiter

Overview:
- Shares the single AXI-lite memory slave (SRAM model) between two masters: IFU (read-only) and LSU (read/write).
- Sits between the core's IFU/LSU AXI-lite master ports and the memory slave.
- Exactly one transaction is outstanding at a time.
- Arbitration is round-robin, so neither master starves.

Parameters:
- RR_INIT, 1'b0: initial value of last_grant (0 = IFU last served, so LSU wins the first tie).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- ifu_araddr/ifu_arvalid/ifu_arready  in/in/out  AXI_ADDR/1/1  IFU AR channel.
- ifu_rdata/ifu_rresp/ifu_rvalid/ifu_rready  out/out/out/in  AXI_DATA/AXI_RESP/1/1  IFU R channel.
- lsu_araddr/lsu_arvalid/lsu_arready  in/in/out  AXI_ADDR/1/1  LSU AR channel.
- lsu_rdata/lsu_rresp/lsu_rvalid/lsu_rready  out/out/out/in  AXI_DATA/AXI_RESP/1/1  LSU R channel.
- lsu_awaddr/lsu_awvalid/lsu_awready  in/in/out  AXI_ADDR/1/1  LSU AW channel.
- lsu_wdata/lsu_wstrb/lsu_wvalid/lsu_wready  in/in/in/out  AXI_DATA/AXI_WSTRB/1/1  LSU W channel.
- lsu_bresp/lsu_bvalid/lsu_bready  out/out/in  AXI_RESP/1/1  LSU B channel.
- mem_* (araddr, arvalid, arready, rdata, rresp, rvalid, rready, awaddr, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready)  mirrored directions  same widths  slave-side AXI-lite.
- Widths: AXI_ADDR=32, AXI_DATA=32, AXI_WSTRB=4, AXI_RESP=2.

Behaviour:
- Registered state: state, last_grant (0=IFU, 1=LSU), aw_done, w_done.
- Everything else is combinational from state and inputs.
- States:
  - IDLE: no channel forwarded. Every master-side ready/valid output = 0. Every mem valid/ready output = 0.
  - IFU_AR, IFU_R, LSU_AR, LSU_R, LSU_W, LSU_B: forward only the named channel(s) between the granted master and mem. Every non-forwarded output = 0, data outputs = 0.
- IDLE grant rules (evaluated every cycle):
  - LSU request = lsu_awvalid | lsu_arvalid. Within LSU, a write beats a read.
  - Only one master requesting: grant it.
  - Both requesting: grant the master != last_grant.
  - On grant: update last_grant; go to IFU_AR, LSU_AR or LSU_W.
  - Grant costs exactly 1 bubble cycle (IDLE); no ready is asserted in the grant cycle.
- xx_AR: mem_araddr/arvalid <- master; master arready <- mem_arready. On mem_arvalid & mem_arready go to xx_R.
- xx_R: master rdata/rresp/rvalid <- mem; mem_rready <- master rready. On the R handshake return to IDLE.
- LSU_W:
  - AW and W forwarded independently: mem_awvalid = lsu_awvalid & !aw_done; mem_wvalid = lsu_wvalid & !w_done. Same masking on the LSU readies.
  - Each handshake sets its done flag.
  - Leave for LSU_B when both are complete, counting same-cycle handshakes.
  - Both handshakes in one cycle: go straight to LSU_B.
- LSU_B: forward B. On handshake clear aw_done/w_done and go to IDLE.
- Minimum latency vs. a zero-wait slave:
  - Read: 1 (grant) + 1 (AR) + R cycles.
  - Write: 1 (grant) + 1 (AW/W) + B cycles.
- Invariants:
  - mem_*valid never asserted in IDLE.
  - At most one of {AR, AW/W} is active on mem.
  - A master whose request is not granted sees ready = 0 until granted.
- Reset:
  - Async assert forces state=IDLE, last_grant=RR_INIT, aw_done=w_done=0.
  - Consequently all valid/ready outputs = 0 and data = 0.
  - An in-flight transaction is abandoned; memory is reset on the same rst.
- Master drops valid before handshake (protocol violation): the FSM holds in its state; no timeout.
- rresp/bresp are passed through unmodified.

Decomposition:
- Shared package (axi_pkg): AXI width constants; arb_state_e enum (IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R, LSU_W, LSU_B); grant_e (GRANT_IFU=0, GRANT_LSU=1).
- One sub-module is natural: rr_arbiter2. Inputs: req[1:0], last_grant. Outputs: one-hot gnt. Purely combinational; the parent registers last_grant.

Test Plan:
- IFU alone, ifu_araddr=0x80000000, mem returns 0x00000413 after 3 wait cycles -> ifu_rdata=0x00000413, ifu_rresp=0; lsu_* outputs stay 0; back to IDLE 1 cycle after rready.
- IFU read and LSU read requested in the same cycle after reset (last_grant=0) -> LSU granted first (addr 0x80001000), IFU AR forwarded only after LSU R handshake plus 1 IDLE cycle; last_grant ends at 0.
- LSU write awaddr=0x80002000, wdata=0xDEADBEEF, wstrb=0xF; mem raises wready 2 cycles before awready -> each accepted exactly once, then bresp=0 forwarded, lsu_bvalid high 1 cycle with bready=1.
- LSU awvalid and arvalid asserted together -> write served first; read granted on the next IDLE only if IFU is idle.
- rst asserted mid-read during IFU_R with mem_rvalid=1 -> all outputs 0 asynchronously (before next clk edge); after release, the first grant follows RR_INIT.
- Back-to-back IFU and LSU reads for 100 cycles, both always valid -> grants strictly alternate; no master waits more than one other transaction.
